// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: checks PC-generated fetch addresses, issues in-order
// reads to instruction memory and returns instructions (or faults) in request order.
module instr_fetch_unit #(
   parameter int          DEPTH               = 2,
   parameter logic [31:0] START_ADDRESS       = 32'h01000000,
   parameter logic [31:0] UPPER_ADDRESS_LIMIT = 32'h01000FFC
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_pc,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic [31:0] mem_addr,
   input  logic        mem_rsp_valid,
   input  logic [31:0] mem_rsp_data,
   input  logic        flush,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic        instr_fault
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [AW-1:0] head_q, head_d, tail_q, tail_d;
   logic [CW-1:0] count_q, count_d, drop_q, drop_d;

   logic [31:0]      pc_q   [DEPTH];
   logic [31:0]      data_q [DEPTH];
   logic [DEPTH-1:0] fault_q;
   logic [DEPTH-1:0] filled_q;

   logic          legal, credit, head_live, push, pop;
   logic          fill_hit, rsp_drop, rsp_fill;
   logic [AW-1:0] fill_idx, idx;
   logic [CW-1:0] unfilled_n;

   assign legal = (req_pc[1:0] == 2'b00) && (req_pc >= START_ADDRESS)
                  && (req_pc <= UPPER_ADDRESS_LIMIT);
   // Responses still owed to flushed fetches hold their slot until they arrive.
   assign credit = ({1'b0, count_q} + {1'b0, drop_q}) < (CW+1)'(DEPTH);

   assign mem_req_valid = rst && req_valid && legal && credit && !flush;
   assign mem_addr      = req_pc;
   assign req_ready     = rst && credit && !flush && (!legal || mem_req_ready);

   assign head_live   = (count_q != '0);
   assign instr_valid = head_live && filled_q[head_q] && !flush;
   assign instr       = head_live ? data_q[head_q] : 32'h0;
   assign instr_pc    = head_live ? pc_q[head_q]   : 32'h0;
   assign instr_fault = head_live && fault_q[head_q];

   assign push = req_valid && req_ready;
   assign pop  = instr_valid && instr_ready;

   // Locate the oldest entry still waiting for read data and count the waiters.
   always_comb begin
      fill_hit   = 1'b0;
      fill_idx   = head_q;
      unfilled_n = '0;
      idx        = head_q;
      for (int i = 0; i < DEPTH; i++) begin
         idx = head_q + AW'(i);
         if ((CW'(i) < count_q) && !filled_q[idx]) begin
            unfilled_n = unfilled_n + CW'(1);
            if (!fill_hit) begin
               fill_hit = 1'b1;
               fill_idx = idx;
            end
         end
      end
   end

   assign rsp_drop = mem_rsp_valid && (drop_q != '0);
   assign rsp_fill = mem_rsp_valid && (drop_q == '0) && fill_hit;

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      drop_d  = drop_q - CW'(rsp_drop);
      if (flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
         drop_d  = drop_q - CW'(rsp_drop) + unfilled_n - CW'(rsp_fill);
      end else begin
         if (push) tail_d = tail_q + AW'(1);
         if (pop)  head_d = head_q + AW'(1);
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         drop_q  <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         drop_q  <= drop_d;
      end
   end

   // Entry payload is only meaningful below count_q, so it needs no reset.
   always_ff @(posedge clk) begin
      if (push) begin
         pc_q[tail_q]     <= req_pc;
         fault_q[tail_q]  <= !legal;
         filled_q[tail_q] <= !legal;
         data_q[tail_q]   <= 32'h0;
      end
      if (rsp_fill) begin
         data_q[fill_idx]   <= mem_rsp_data;
         filled_q[fill_idx] <= 1'b1;
      end
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed fetch/flush/fault/reset scenarios, checked
// against a queue-based reference model every cycle plus literal expectations.
module tb_instr_fetch_unit;

   localparam int          DEPTH = 2;
   localparam logic [31:0] START = 32'h01000000;
   localparam logic [31:0] UPPER = 32'h01000FFC;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic [31:0] req_pc = 32'h0;
   logic        mem_req_ready = 1'b1;
   logic        mem_rsp_valid = 1'b0;
   logic [31:0] mem_rsp_data = 32'h0;
   logic        flush = 1'b0;
   logic        instr_ready = 1'b0;
   logic        req_ready, mem_req_valid, instr_valid, instr_fault;
   logic [31:0] mem_addr, instr, instr_pc;

   int checks = 0;
   int failures = 0;
   int mrv_cnt = 0;
   int mrv_start;

   instr_fetch_unit #(.DEPTH(DEPTH), .START_ADDRESS(START), .UPPER_ADDRESS_LIMIT(UPPER)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_pc(req_pc),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .flush(flush),
      .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
      .instr_pc(instr_pc), .instr_fault(instr_fault)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model: list of accepted fetches in order, plus responses owed to flushed reads.
   typedef struct {
      logic [31:0] pc;
      bit          fault;
      bit          filled;
      logic [31:0] data;
   } ent_t;
   ent_t mq[$];
   int   mdrop = 0;

   initial begin
      bit e_legal, e_credit, e_rr, e_mrv, e_iv, e_flt, found;
      logic [31:0] e_instr, e_pc;
      int n;
      ent_t e;
      forever begin
         @(negedge clk);
         if (mem_req_valid) mrv_cnt++;
         e_legal  = (req_pc[1:0] == 2'b00) && (req_pc >= START) && (req_pc <= UPPER);
         e_credit = (mq.size() + mdrop) < DEPTH;
         e_rr     = rst && e_credit && !flush && (!e_legal || mem_req_ready);
         e_mrv    = rst && req_valid && e_legal && e_credit && !flush;
         e_iv     = rst && (mq.size() > 0) && mq[0].filled && !flush;
         e_instr  = (mq.size() > 0) ? mq[0].data : 32'h0;
         e_pc     = (mq.size() > 0) ? mq[0].pc : 32'h0;
         e_flt    = (mq.size() > 0) ? mq[0].fault : 1'b0;
         chk("model req_ready", req_ready, e_rr);
         chk("model mem_req_valid", mem_req_valid, e_mrv);
         chk("model instr_valid", instr_valid, e_iv);
         if (e_mrv) chk("model mem_addr", mem_addr, req_pc);
         if (e_iv || !rst) begin
            chk("model instr", instr, rst ? e_instr : 32'h0);
            chk("model instr_pc", instr_pc, rst ? e_pc : 32'h0);
            chk("model instr_fault", instr_fault, rst ? e_flt : 1'b0);
         end
         if (!rst) begin
            mq.delete();
            mdrop = 0;
         end else begin
            if (mem_rsp_valid) begin
               if (mdrop > 0) mdrop--;
               else begin
                  found = 0;
                  for (int i = 0; i < mq.size(); i++)
                     if (!found && !mq[i].filled) begin
                        mq[i].filled = 1;
                        mq[i].data   = mem_rsp_data;
                        found = 1;
                     end
               end
            end
            if (flush) begin
               n = 0;
               foreach (mq[i]) if (!mq[i].filled) n++;
               mdrop += n;
               mq.delete();
            end else begin
               if (e_iv && instr_ready) void'(mq.pop_front());
               if (req_valid && e_rr) begin
                  e.pc = req_pc; e.fault = !e_legal; e.filled = !e_legal; e.data = 32'h0;
                  mq.push_back(e);
               end
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end

   task automatic fault_case(input logic [31:0] pc);
      req_valid = 1; req_pc = pc;
      #1;
      chk("fault mem_req_valid", mem_req_valid, 1'b0);
      chk("fault req_ready", req_ready, 1'b1);
      tick();
      req_valid = 0;
      #1;
      chk("fault instr_valid", instr_valid, 1'b1);
      chk("fault instr_fault", instr_fault, 1'b1);
      chk("fault instr", instr, 32'h0);
      chk("fault instr_pc", instr_pc, pc);
      instr_ready = 1;
      tick();
      instr_ready = 0;
   endtask

   initial begin
      #1 rst = 0;
      req_valid = 1; req_pc = 32'h01000000;
      #2;
      chk("reset req_ready", req_ready, 1'b0);
      chk("reset mem_req_valid", mem_req_valid, 1'b0);
      chk("reset instr_valid", instr_valid, 1'b0);
      tick(); tick();
      rst = 1; req_valid = 0;
      tick();

      // single legal fetch
      mrv_start = mrv_cnt;
      req_valid = 1; req_pc = 32'h01000000;
      #1;
      chk("t1 mem_req_valid", mem_req_valid, 1'b1);
      chk("t1 mem_addr", mem_addr, 32'h01000000);
      tick();
      req_valid = 0;
      tick();
      mem_rsp_valid = 1; mem_rsp_data = 32'h8C010004;
      tick();
      mem_rsp_valid = 0;
      #1;
      chk("t1 instr_valid", instr_valid, 1'b1);
      chk("t1 instr", instr, 32'h8C010004);
      chk("t1 instr_pc", instr_pc, 32'h01000000);
      chk("t1 instr_fault", instr_fault, 1'b0);
      chk("t1 mem_req pulses", mrv_cnt - mrv_start, 1);
      instr_ready = 1;
      tick();
      instr_ready = 0;
      #1 chk("t1 drained", instr_valid, 1'b0);

      // back-to-back with full queue
      req_valid = 1; req_pc = 32'h01000000;
      #1 chk("t2 A ready", req_ready, 1'b1);
      tick();
      req_pc = 32'h01000004;
      #1 chk("t2 B ready", req_ready, 1'b1);
      tick();
      req_pc = 32'h01000008;
      #1 chk("t2 C held", req_ready, 1'b0);
      tick();
      chk("t2 C still held", req_ready, 1'b0);
      mem_rsp_valid = 1; mem_rsp_data = 32'h11111111;
      tick();
      mem_rsp_data = 32'h22222222;
      tick();
      mem_rsp_valid = 0;
      #1;
      chk("t2 A instr", instr, 32'h11111111);
      chk("t2 A pc", instr_pc, 32'h01000000);
      chk("t2 held while full", req_ready, 1'b0);
      instr_ready = 1;
      tick();
      instr_ready = 0;
      #1;
      chk("t2 C ready after pop", req_ready, 1'b1);
      chk("t2 B instr", instr, 32'h22222222);
      chk("t2 B pc", instr_pc, 32'h01000004);
      tick();
      req_valid = 0;
      mem_rsp_valid = 1; mem_rsp_data = 32'h33333333;
      tick();
      mem_rsp_valid = 0; instr_ready = 1;
      #1 chk("t2 B still head", instr_pc, 32'h01000004);
      tick();
      #1;
      chk("t2 C instr", instr, 32'h33333333);
      chk("t2 C pc", instr_pc, 32'h01000008);
      tick();
      instr_ready = 0;
      #1 chk("t2 empty", instr_valid, 1'b0);

      // faults and boundaries
      fault_case(32'h01000002);
      fault_case(32'h01001000);
      fault_case(32'h00FFFFFC);
      req_valid = 1; req_pc = 32'h01000FFC;
      #1 chk("upper limit legal", mem_req_valid, 1'b1);
      tick();
      req_valid = 0;
      mem_rsp_valid = 1; mem_rsp_data = 32'hDEADBEEF;
      tick();
      mem_rsp_valid = 0;
      #1;
      chk("upper instr", instr, 32'hDEADBEEF);
      chk("upper fault", instr_fault, 1'b0);
      instr_ready = 1;
      tick();
      instr_ready = 0;
      mem_req_ready = 0; req_valid = 1; req_pc = 32'h01000060;
      #1;
      chk("mem stall req_ready", req_ready, 1'b0);
      chk("mem stall mem_req_valid", mem_req_valid, 1'b1);
      req_pc = 32'h01000061;
      #1 chk("fault ignores mem stall", req_ready, 1'b1);
      req_valid = 0; mem_req_ready = 1;
      tick();

      // fault entry waits behind an unfilled fetch
      req_valid = 1; req_pc = 32'h01000010;
      tick();
      req_pc = 32'h02000000;
      tick();
      req_valid = 0;
      for (int i = 0; i < 4; i++) begin
         #1 chk("t4 fault waits", instr_valid, 1'b0);
         tick();
      end
      mem_rsp_valid = 1; mem_rsp_data = 32'h44444444;
      tick();
      mem_rsp_valid = 0;
      #1;
      chk("t4 legal first pc", instr_pc, 32'h01000010);
      chk("t4 legal first instr", instr, 32'h44444444);
      instr_ready = 1;
      tick();
      instr_ready = 0;
      #1;
      chk("t4 fault valid", instr_valid, 1'b1);
      chk("t4 fault pc", instr_pc, 32'h02000000);
      chk("t4 fault flag", instr_fault, 1'b1);
      instr_ready = 1;
      tick();
      instr_ready = 0;

      // flush with two reads in flight
      req_valid = 1; req_pc = 32'h01000000;
      tick();
      req_pc = 32'h01000004;
      tick();
      req_valid = 0; flush = 1;
      #1 chk("t5 flush blocks accept", req_ready, 1'b0);
      tick();
      flush = 0;
      #1 chk("t5 credit held by drops", req_ready, 1'b0);
      for (int i = 0; i < 2; i++) begin
         mem_rsp_valid = 1; mem_rsp_data = 32'hAAAA0000 + i;
         tick();
         mem_rsp_valid = 0;
         #1 chk("t5 dropped rsp", instr_valid, 1'b0);
      end
      req_valid = 1; req_pc = 32'h01000020;
      tick();
      req_valid = 0;
      mem_rsp_valid = 1; mem_rsp_data = 32'h55555555;
      tick();
      mem_rsp_valid = 0;
      #1;
      chk("t5 refetch instr", instr, 32'h55555555);
      chk("t5 refetch pc", instr_pc, 32'h01000020);
      instr_ready = 1;
      tick();
      instr_ready = 0;

      // flush coincident with the only outstanding response
      req_valid = 1; req_pc = 32'h01000030;
      tick();
      req_valid = 0; flush = 1; mem_rsp_valid = 1; mem_rsp_data = 32'h66666666;
      tick();
      flush = 0; mem_rsp_valid = 0;
      #1 chk("t6 nothing delivered", instr_valid, 1'b0);
      req_valid = 1; req_pc = 32'h01000040;
      tick();
      req_pc = 32'h01000044;
      #1 chk("t6 no leftover drop", req_ready, 1'b1);
      tick();
      req_valid = 0;
      mem_rsp_valid = 1; mem_rsp_data = 32'h77777777;
      tick();
      mem_rsp_data = 32'h88888888;
      tick();
      mem_rsp_valid = 0;
      #1 chk("t6 first instr", instr, 32'h77777777);
      instr_ready = 1;
      tick();
      chk("t6 second instr", instr, 32'h88888888);
      tick();
      instr_ready = 0;

      // async reset mid-fetch
      req_valid = 1; req_pc = 32'h01000050;
      tick();
      req_pc = 32'h01000054;
      #1 chk("t7 pending pc", instr_pc, 32'h01000050);
      rst = 0;
      #1;
      chk("t7 rst instr_valid", instr_valid, 1'b0);
      chk("t7 rst req_ready", req_ready, 1'b0);
      chk("t7 rst mem_req_valid", mem_req_valid, 1'b0);
      chk("t7 rst instr", instr, 32'h0);
      chk("t7 rst instr_pc", instr_pc, 32'h0);
      chk("t7 rst instr_fault", instr_fault, 1'b0);
      tick();
      rst = 1; req_valid = 0;
      mem_rsp_valid = 1; mem_rsp_data = 32'h99999999;
      tick();
      mem_rsp_valid = 0;
      #1 chk("t7 late rsp ignored", instr_valid, 1'b0);
      tick(); tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
